// File: rtl/debug_reg_scanner.sv
// debug_reg_scanner: walks a register index range over the processor debug read port
// and streams (reg, value) beats, optionally only those that changed since the last scan.
module debug_reg_scanner #(
    parameter int NREG = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  first_reg,
    input  logic [3:0]  last_reg,
    input  logic        changed_only,
    output logic [3:0]  DBtheReg,
    input  logic [31:0] DBtheRegVal,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_reg,
    output logic [31:0] out_val,
    output logic        out_changed,
    output logic        busy,
    output logic        done,
    output logic [7:0]  scan_count
);
    typedef enum logic [1:0] {IDLE, SELECT, OUTPUT, DONE} state_t;
    state_t state, state_n;
    logic [3:0] idx, idx_inc, last_q;
    logic co_q, changed, at_last, fire, skip, advance;
    logic [31:0] shadow [NREG];
    logic [NREG-1:0] shadow_v;
    always_comb begin
        changed = !shadow_v[idx] || (shadow[idx] != DBtheRegVal);
        at_last = idx == last_q;
        fire = out_valid && out_ready;
        skip = co_q && !changed;
        idx_inc = idx + 4'd1;
        advance = !at_last && ((state == SELECT && skip) || (state == OUTPUT && fire));
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SELECT : IDLE;
            SELECT:  state_n = !skip ? OUTPUT : at_last ? DONE : SELECT;
            OUTPUT:  state_n = !fire ? OUTPUT : at_last ? DONE : SELECT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= 4'd0;
            last_q <= 4'd0;
            co_q <= 1'b0;
            DBtheReg <= 4'd0;
            out_valid <= 1'b0;
            out_reg <= 4'd0;
            out_val <= 32'd0;
            out_changed <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            scan_count <= 8'd0;
            shadow_v <= '0;
        end else begin
            out_valid <= state_n == OUTPUT;
            busy <= state_n == SELECT || state_n == OUTPUT;
            done <= state_n == DONE;
            if (state != DONE && state_n == DONE)
                scan_count <= scan_count + 8'd1;
            if (state == IDLE && start) begin
                idx <= first_reg;
                DBtheReg <= first_reg;
                last_q <= last_reg;
                co_q <= changed_only;
            end
            if (state == SELECT) begin
                out_val <= DBtheRegVal;
                out_reg <= idx;
                out_changed <= changed;
                shadow_v[idx] <= 1'b1;
            end
            if (advance) begin
                idx <= idx_inc;
                DBtheReg <= idx_inc;
            end
        end
    end
    // Shadow data needs no reset: shadow_v gates every use of it.
    always_ff @(posedge clk) begin
        if (state == SELECT)
            shadow[idx] <= DBtheRegVal;
    end
endmodule
